// File: rtl/ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb3lite_sram_slave
//
// AHB-Lite responder backed by a word-organised on-chip SRAM. It decodes
// the address phase, optionally stretches each OKAY data phase with a fixed
// number of wait states, performs byte / halfword / word accesses on
// little-endian byte lanes, and answers illegal transfers with the
// two-cycle AHB ERROR response.
//
// Parameters
//   MEM_DEPTH   : number of 32-bit words in the SRAM
//   HADDR_SIZE  : address bus width
//   HDATA_SIZE  : data bus width (only 32 is supported)
//   WAIT_STATES : HREADYOUT-low cycles inserted in every OKAY data phase (0..15)
//
// Ports
//   HCLK        : clock, all logic on the rising edge
//   HRESET      : synchronous active-high reset
//   HSEL        : slave select
//   HADDR       : byte address (address phase)
//   HWDATA      : write data (data phase)
//   HRDATA      : read data, the addressed word while in the data cycle, else 0
//   HWRITE      : 1 = write, 0 = read
//   HSIZE       : transfer size
//   HBURST      : burst type, accepted and ignored (beats decode independently)
//   HPROT       : protection attributes, accepted and ignored
//   HTRANS      : IDLE / BUSY / NONSEQ / SEQ
//   HREADY      : bus-level ready (output of the slave mux)
//   HREADYOUT   : this slave's ready
//   HRESP       : 0 = OKAY, 1 = ERROR
// ---------------------------------------------------------------------------
module ahb3lite_sram_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    // The counter is loaded with WAIT_STATES-1 on entry to WAIT; guard the
    // zero case so the constant never goes negative.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  ready_q;
    logic                  resp_q;

    logic [AW-1:0]         idx_q;
    logic [1:0]            offset_q;
    logic [1:0]            size_q;
    logic                  write_q;

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    logic [AW-1:0]         addr_index;
    logic                  upper_bits_set;
    logic                  index_out_of_range;
    logic                  size_illegal;
    logic                  misaligned;
    logic                  transfer_illegal;
    logic                  accept;
    logic [3:0]            lane_en;
    logic                  unused_inputs;

    // HBURST and HPROT carry no meaning for a plain SRAM.
    assign unused_inputs = ^{HBURST, HPROT};

    assign addr_index = HADDR[AW+1:2];

    // Any address bit above the decoded word range makes the transfer illegal.
    generate
        if (HADDR_SIZE > AW + 2) begin : g_upper
            assign upper_bits_set = |HADDR[HADDR_SIZE-1:AW+2];
        end else begin : g_no_upper
            assign upper_bits_set = 1'b0;
        end
    endgenerate

    // Only a non-power-of-two depth leaves unused codes inside the decoded range.
    generate
        if (MEM_DEPTH < (1 << AW)) begin : g_range
            assign index_out_of_range = (32'(addr_index) >= 32'(MEM_DEPTH));
        end else begin : g_full_range
            assign index_out_of_range = 1'b0;
        end
    endgenerate

    assign size_illegal     = HSIZE[2] | (HSIZE[1:0] == 2'b11);
    assign misaligned       = ((HSIZE == SIZE_HALF) && HADDR[0]) ||
                              ((HSIZE == SIZE_WORD) && (HADDR[1:0] != 2'b00));
    assign transfer_illegal = size_illegal | misaligned | upper_bits_set | index_out_of_range;

    // A new address phase is taken only while this slave shows ready, so
    // nothing is accepted during WAIT or ERR1 even if HREADY misbehaves.
    assign accept = HSEL & HREADY & HTRANS[1] & ready_q;

    // Single FSM: state, wait counter and the registered HREADYOUT/HRESP all
    // move together so the outputs are glitch-free flops.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            ready_q  <= 1'b1;
            resp_q   <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= ST_DATA;
                        ready_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                ST_ERR1: begin
                    state   <= ST_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b1;
                end

                // IDLE, DATA and ERR2 all end with HREADYOUT high, so each of
                // them can pick up a pipelined address phase at this edge.
                default: begin
                    if (accept) begin
                        idx_q    <= addr_index;
                        offset_q <= HADDR[1:0];
                        size_q   <= HSIZE[1:0];
                        write_q  <= HWRITE;
                        if (transfer_illegal) begin
                            state   <= ST_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                            ready_q  <= 1'b0;
                            resp_q   <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            ready_q <= 1'b1;
                            resp_q  <= 1'b0;
                        end
                    end else begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Little-endian lane selection; illegal sizes never reach DATA, so the
    // default only ever serves word transfers.
    always_comb begin
        lane_en = 4'b1111;
        case (size_q)
            2'b00:   lane_en = 4'b0001 << offset_q;
            2'b01:   lane_en = 4'b0011 << offset_q;
            default: lane_en = 4'b1111;
        endcase
    end

    // Writes land at the edge that closes DATA. Reset on that same edge
    // abandons the transfer, so the commit is suppressed.
    always_ff @(posedge HCLK) begin
        if (!HRESET && (state == ST_DATA) && write_q) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (lane_en[lane]) begin
                    mem[idx_q][8*lane +: 8] <= HWDATA[8*lane +: 8];
                end
            end
        end
    end

    // The read port is asynchronous so a read directly behind a write to the
    // same word sees the value committed at the edge that opened its DATA cycle.
    assign HRDATA    = (state == ST_DATA) ? mem[idx_q] : '0;
    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_sram_slave
//
// Two instances share one master: dut0 runs with no wait states, dut1 with
// two. The reference model turns every accepted address phase into a list
// of the output cycles it must produce (wait cycles, the data cycle, or the
// two error cycles) and keeps its own copy of each memory.
// ---------------------------------------------------------------------------
module tb_ahb3lite_sram_slave;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [2:0]  hburst = '0;
    logic [3:0]  hprot = '0;
    logic [1:0]  htrans = '0;
    logic        hold = 1'b0;
    int          act = 0;

    logic        ro0, rsp0, ro1, rsp1;
    logic [31:0] rd0, rd1;
    logic        hsel0, hsel1, hrdy0, hrdy1;
    logic        ro_act, rsp_act;
    logic [31:0] rd_act;

    int          tests = 0;
    int          fails = 0;
    logic        chk_en = 1'b0;

    always #5 clk = ~clk;

    // Each slave sees its own ready as HREADY; 'hold' mimics another slave
    // stretching the bus.
    assign hsel0   = hsel && (act == 0);
    assign hsel1   = hsel && (act == 1);
    assign hrdy0   = ro0 && !hold;
    assign hrdy1   = ro1 && !hold;
    assign ro_act  = (act == 1) ? (ro1 && !hold) : (ro0 && !hold);
    assign rsp_act = (act == 1) ? rsp1 : rsp0;
    assign rd_act  = (act == 1) ? rd1 : rd0;

    ahb3lite_sram_slave #(
        .MEM_DEPTH(DEPTH), .HADDR_SIZE(32), .HDATA_SIZE(32), .WAIT_STATES(0)
    ) dut0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(rd0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HREADY(hrdy0), .HREADYOUT(ro0), .HRESP(rsp0)
    );

    ahb3lite_sram_slave #(
        .MEM_DEPTH(DEPTH), .HADDR_SIZE(32), .HDATA_SIZE(32), .WAIT_STATES(2)
    ) dut1 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel1), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(rd1), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HREADY(hrdy1), .HREADYOUT(ro1), .HRESP(rsp1)
    );

    // One expected output cycle: ready, resp, and whether it is the final
    // OKAY data cycle (which carries read data and commits a write).
    typedef struct packed {
        logic       rdy;
        logic       rsp;
        logic       fin;
        logic       wr;
        logic [7:0] idx;
        logic [3:0] be;
    } ent_t;

    ent_t        sched [2][4];
    int          slen [2] = '{0, 0};
    int          ws_of [2] = '{0, 2};
    logic [31:0] mmem [2][DEPTH];
    bit          known [2][DEPTH];

    function automatic ent_t mk(input logic rdy, input logic rsp, input logic fin,
                                input logic wr, input logic [7:0] idx, input logic [3:0] be);
        ent_t e;
        e.rdy = rdy; e.rsp = rsp; e.fin = fin; e.wr = wr; e.idx = idx; e.be = be;
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
        end
    endtask

    // Reference model: advance one cycle per rising edge.
    always @(posedge clk) begin
        ent_t       cur;
        logic       bad;
        logic [3:0] be;
        for (int d = 0; d < 2; d++) begin
            if (hreset) begin
                slen[d] = 0;
            end else begin
                cur = (slen[d] > 0) ? sched[d][0] : mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
                if (slen[d] > 0 && cur.fin && cur.wr) begin
                    for (int b = 0; b < 4; b++)
                        if (cur.be[b]) mmem[d][cur.idx][8*b +: 8] = hwdata[8*b +: 8];
                    if (cur.be == 4'hF) known[d][cur.idx] = 1'b1;
                end
                if (slen[d] > 0) begin
                    for (int k = 0; k < 3; k++) sched[d][k] = sched[d][k+1];
                    slen[d]--;
                end
                if (hsel && (act == d) && cur.rdy && !hold && htrans[1]) begin
                    bad = (hsize > 3'd2) ||
                          (hsize == 3'd1 && (haddr % 2) != 0) ||
                          (hsize == 3'd2 && (haddr % 4) != 0) ||
                          (haddr >= 32'd1024);
                    case (hsize)
                        3'd0:    be = 4'b0001 << haddr[1:0];
                        3'd1:    be = 4'b0011 << haddr[1:0];
                        default: be = 4'b1111;
                    endcase
                    if (bad) begin
                        sched[d][0] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
                        sched[d][1] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
                        slen[d] = 2;
                    end else begin
                        for (int w = 0; w < ws_of[d]; w++)
                            sched[d][w] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
                        sched[d][ws_of[d]] = mk(1'b1, 1'b0, 1'b1, hwrite, haddr[9:2], be);
                        slen[d] = ws_of[d] + 1;
                    end
                end
            end
        end
    end

    // Compare both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        ent_t e;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                e = (slen[d] > 0) ? sched[d][0] : mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
                cmp($sformatf("dut%0d_hreadyout", d), {31'd0, (d == 1) ? ro1 : ro0}, {31'd0, e.rdy});
                cmp($sformatf("dut%0d_hresp", d), {31'd0, (d == 1) ? rsp1 : rsp0}, {31'd0, e.rsp});
                if (!e.fin)
                    cmp($sformatf("dut%0d_hrdata_idle", d), (d == 1) ? rd1 : rd0, 32'd0);
                else if (known[d][e.idx])
                    cmp($sformatf("dut%0d_hrdata_word%0d", d, e.idx), (d == 1) ? rd1 : rd0, mmem[d][e.idx]);
            end
        end
    end

    // Drive one address phase (called at a falling edge) and return at the
    // falling edge after it is taken; non-transfers just occupy one cycle.
    task automatic apply_stimulus(input logic [31:0] addr, input logic [2:0] size,
                                  input logic wr, input logic [31:0] wdata,
                                  input logic [1:0] trans, input logic sel, output int stalls);
        haddr  = addr;
        hsize  = size;
        hwrite = wr;
        htrans = trans;
        hsel   = sel;
        hburst = 3'($urandom_range(0, 7));
        hprot  = 4'($urandom_range(0, 15));
        stalls = 0;
        if (!(sel && trans[1])) begin
            @(posedge clk);
            @(negedge clk);
        end else begin
            while (!ro_act && stalls < 40) begin
                @(negedge clk);
                stalls++;
            end
            if (stalls >= 40) begin
                tests++;
                fails++;
                $display("[TB] FAIL accept_timeout: got no HREADYOUT after %0d cycles, expected at most 15", stalls);
            end
            @(posedge clk);
            @(negedge clk);
            if (wr) hwdata = wdata;
        end
        htrans = 2'b00;
    endtask

    // Follow the data phase that started at this falling edge to its end.
    task automatic check_output(output int cycles, output logic [31:0] rdata,
                                output logic rsp, output logic first_rdy, output logic first_rsp);
        first_rdy = ro_act;
        first_rsp = rsp_act;
        cycles = 1;
        while (!ro_act && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        rdata = rd_act;
        rsp   = rsp_act;
    endtask

    task automatic drain();
        htrans = 2'b00;
        hsel   = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int          st, cyc;
        logic [31:0] rdata;
        logic        rsp, frdy, frsp;
        logic [31:0] addr;
        logic [2:0]  size;
        int          off;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("reset_hreadyout0", {31'd0, ro0}, 32'd1);
        cmp("reset_hresp0", {31'd0, rsp0}, 32'd0);
        cmp("reset_hrdata0", rd0, 32'd0);
        cmp("reset_hreadyout1", {31'd0, ro1}, 32'd1);
        cmp("reset_hresp1", {31'd0, rsp1}, 32'd0);
        cmp("reset_hrdata1", rd1, 32'd0);
        hreset = 1'b0;
        chk_en = 1'b1;

        // Give every word a known value in both memories.
        for (int d = 0; d < 2; d++) begin
            act = d;
            for (int i = 0; i < DEPTH; i++)
                apply_stimulus(32'(i * 4), 3'd2, 1'b1, $urandom, 2'b10, 1'b1, st);
            drain();
        end

        // Zero wait states: write then read back-to-back
        act = 0;
        apply_stimulus(32'h8, 3'd2, 1'b1, 32'hDEADBEEF, 2'b10, 1'b1, st);
        apply_stimulus(32'h8, 3'd2, 1'b0, 32'h0, 2'b10, 1'b1, st);
        cmp("raw_ws0_stalls", 32'(st), 32'd0);
        check_output(cyc, rdata, rsp, frdy, frsp);
        cmp("raw_ws0_rdata", rdata, 32'hDEADBEEF);
        cmp("raw_ws0_resp", {31'd0, rsp}, 32'd0);
        cmp("raw_ws0_cycles", 32'(cyc), 32'd1);

        // Byte and halfword lane merging
        apply_stimulus(32'h10, 3'd2, 1'b1, 32'h11223344, 2'b10, 1'b1, st);
        apply_stimulus(32'h12, 3'd0, 1'b1, 32'h00AA0000, 2'b10, 1'b1, st);
        apply_stimulus(32'h10, 3'd1, 1'b1, 32'h0000BBCC, 2'b10, 1'b1, st);
        apply_stimulus(32'h10, 3'd2, 1'b0, 32'h0, 2'b11, 1'b1, st);
        check_output(cyc, rdata, rsp, frdy, frsp);
        cmp("lanes_rdata", rdata, 32'h11AABBCC);
        cmp("lanes_model_word", mmem[0][4], 32'h11AABBCC);

        // Out-of-range word write errors and leaves memory alone
        apply_stimulus(32'h0, 3'd2, 1'b1, 32'h01234567, 2'b10, 1'b1, st);
        apply_stimulus(32'h400, 3'd2, 1'b1, 32'h99999999, 2'b10, 1'b1, st);
        check_output(cyc, rdata, rsp, frdy, frsp);
        cmp("err_range_first_ready", {31'd0, frdy}, 32'd0);
        cmp("err_range_first_resp", {31'd0, frsp}, 32'd1);
        cmp("err_range_second_resp", {31'd0, rsp}, 32'd1);
        cmp("err_range_cycles", 32'(cyc), 32'd2);
        apply_stimulus(32'h0, 3'd2, 1'b0, 32'h0, 2'b10, 1'b1, st);
        check_output(cyc, rdata, rsp, frdy, frsp);
        cmp("err_range_old_data", rdata, 32'h01234567);

        // Misaligned halfword read, then IDLE with HSEL high
        apply_stimulus(32'h1, 3'd1, 1'b0, 32'h0, 2'b10, 1'b1, st);
        check_output(cyc, rdata, rsp, frdy, frsp);
        cmp("err_half_cycles", 32'(cyc), 32'd2);
        cmp("err_half_resp", {31'd0, rsp}, 32'd1);
        apply_stimulus(32'h8, 3'd2, 1'b0, 32'h0, 2'b00, 1'b1, st);
        cmp("idle_hreadyout", {31'd0, ro0}, 32'd1);
        cmp("idle_hresp", {31'd0, rsp0}, 32'd0);
        cmp("idle_hrdata", rd0, 32'd0);
        drain();

        // Two wait states: write then read back-to-back
        act = 1;
        apply_stimulus(32'h20, 3'd2, 1'b1, 32'hCAFEF00D, 2'b10, 1'b1, st);
        apply_stimulus(32'h20, 3'd2, 1'b0, 32'h0, 2'b10, 1'b1, st);
        cmp("raw_ws2_write_stalls", 32'(st), 32'd2);
        check_output(cyc, rdata, rsp, frdy, frsp);
        cmp("raw_ws2_cycles", 32'(cyc), 32'd3);
        cmp("raw_ws2_rdata", rdata, 32'hCAFEF00D);

        // Reset during the first wait cycle abandons the write
        apply_stimulus(32'h4, 3'd2, 1'b1, 32'h5A5A1234, 2'b10, 1'b1, st);
        apply_stimulus(32'h4, 3'd2, 1'b1, 32'hFFFFFFFF, 2'b10, 1'b1, st);
        hreset = 1'b1;
        @(negedge clk);
        cmp("midreset_hreadyout", {31'd0, ro1}, 32'd1);
        cmp("midreset_hresp", {31'd0, rsp1}, 32'd0);
        cmp("midreset_hrdata", rd1, 32'd0);
        hreset = 1'b0;
        apply_stimulus(32'h4, 3'd2, 1'b0, 32'h0, 2'b10, 1'b1, st);
        check_output(cyc, rdata, rsp, frdy, frsp);
        cmp("midreset_prior_data", rdata, 32'h5A5A1234);
        drain();

        // Randomised traffic on each instance
        for (int d = 0; d < 2; d++) begin
            act = d;
            for (int i = 0; i < 300; i++) begin
                size = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
                off  = $urandom_range(0, 3);
                if ($urandom_range(0, 3) != 0) begin
                    if (size == 3'd1) off = off & 2;
                    if (size == 3'd2) off = 0;
                end
                addr = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4 + off);
                if ($urandom_range(0, 9) == 0) begin
                    haddr  = addr;
                    hsize  = size;
                    hsel   = 1'b1;
                    htrans = 2'b10;
                    hold   = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    hold   = 1'b0;
                end
                apply_stimulus(addr, size, 1'($urandom_range(0, 1)), $urandom,
                               ($urandom_range(0, 99) < 80) ? {1'b1, 1'($urandom_range(0, 1))}
                                                            : 2'($urandom_range(0, 3)),
                               1'($urandom_range(0, 99) < 90), st);
            end
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 2000000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ahb3lite_sram_slave.md
# ahb3lite_sram_slave

AHB-Lite responder: word-organised on-chip SRAM that completes the read and write transfers issued by the bus master on the `ahb_if` interface. It decodes the address phase, inserts a configurable number of wait states, performs byte, halfword or word accesses, and returns a two-cycle ERROR response for illegal transfers. It is the device-under-test the directed memory tests drive. Transfer encodings (HTRANS, HSIZE, HBURST, HPROT) come from `ahb3lite_pkg`.

## Interface
- `MEM_DEPTH`, 256: number of 32-bit words; the address-decoder width is clog2(MEM_DEPTH).
- `HADDR_SIZE`, 32: address width.
- `HDATA_SIZE`, 32: data width; only 32 is supported.
- `WAIT_STATES`, 0: number of HREADYOUT-low cycles inserted in every OKAY data phase (0..15).
- `HCLK` in 1: clock. All logic is on the rising edge.
- `HRESET` in 1: synchronous, active-high reset.
- `HSEL` in 1: slave select.
- `HADDR` in HADDR_SIZE: byte address.
- `HWDATA` in 32: write data, valid in the data phase.
- `HRDATA` out 32: read data.
- `HWRITE` in 1: 1 = write, 0 = read.
- `HSIZE` in 3: transfer size.
- `HBURST` in 3: burst type. It is accepted and ignored; each beat is decoded independently.
- `HPROT` in 4: protection. It is accepted and ignored.
- `HTRANS` in 2: IDLE/BUSY/NONSEQ/SEQ.
- `HREADY` in 1: bus-level ready (the mux output).
- `HREADYOUT` out 1: slave ready.
- `HRESP` out 1: 0 = OKAY, 1 = ERROR.

## Operation
- An address phase is accepted on a rising edge when HSEL & HREADY & HTRANS is NONSEQ or SEQ. On acceptance the block registers the word index (HADDR[clog2(MEM_DEPTH)+1:2]), the byte offset HADDR[1:0], HSIZE and HWRITE.
- When HSEL=0, HREADY=0, or HTRANS is IDLE/BUSY, nothing is accepted. The next cycle is a zero-wait OKAY with no memory access.
- A transfer is illegal (ERROR) if any of the following holds:
  - HSIZE > word (HSIZE[2]=1 or HSIZE=3'b011).
  - Halfword with HADDR[0]=1.
  - Word with HADDR[1:0]≠0.
  - Word index ≥ MEM_DEPTH, or any HADDR bit above the decoded range is set.
- States:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Legal accept with WAIT_STATES>0 → WAIT, with the counter loaded to WAIT_STATES−1.
    - Legal accept with WAIT_STATES=0 → DATA.
    - Illegal accept → ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. The counter decrements each cycle; at 0 → DATA.
  - DATA: HREADYOUT=1, HRESP=0. The transfer completes at the end of this cycle.
    - A new accept at the same edge follows the same rules as in IDLE.
    - Otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. The memory is not accessed.
    - A new accept at the same edge follows the same rules as in IDLE.
    - Otherwise → IDLE.
- Writes commit at the rising edge that ends DATA. Byte lanes are little-endian:
  - Byte: lane = offset.
  - Halfword: lanes {offset+1, offset}.
  - Word: all four lanes.
  - Unselected lanes are unchanged.
- Reads: in DATA, HRDATA = mem[registered index], the full 32-bit word with all lanes driven. In every other state HRDATA = 0.
- Memory contents are not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0.
- Reset asserted mid-transfer (WAIT, DATA or ERR1): the transfer is abandoned, a pending write does not commit, and the block returns to IDLE on the next edge.
- OKAY data phase length is WAIT_STATES+1 cycles. With WAIT_STATES=0, back-to-back transfers sustain one transfer per cycle.
- ERROR is always exactly 2 cycles, independent of WAIT_STATES.
- Read-after-write to the same address in consecutive cycles: the write commits at the edge that starts the read's data phase, so the read returns the new data. No forwarding path is needed.
- During WAIT and ERR1 (HREADYOUT=0) the block does not accept a new address phase.

## Test plan
- Write 0xDEADBEEF to 0x8 (word, NONSEQ, SINGLE), then read 0x8 → HRDATA=0xDEADBEEF, HRESP=0, each data phase 1 cycle.
- Word write 0x11223344 to 0x10, then byte write 0xAA to 0x12, then halfword write 0xBBCC to 0x10; read 0x10 → 0x11AABBCC.
- Word write to 0x400 (with MEM_DEPTH=256) → HREADYOUT/HRESP = 0/1 then 1/1. A following read of 0x0 returns the unchanged old data.
- Halfword read at 0x1 → two-cycle ERROR. An HTRANS=IDLE cycle with HSEL=1 → 1-cycle OKAY with no access.
- With WAIT_STATES=2: back-to-back write then read to 0x20 → HREADYOUT low for 2 cycles in each data phase, and the read returns the written value.
- With WAIT_STATES=2: a write to 0x4 with HRESET pulsed during the first wait cycle → outputs return to their reset values, and a subsequent read of 0x4 shows the prior contents.
